// File: rtl/uart_rcvr_os_if.sv
// Receive-side pop handshake of uart_rcvr_os: head word, its error flags and valid/ready.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rcvr_os_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_valid_o;
    logic                  rx_ready_i;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  rx_frame_err_o;
    logic                  rx_parity_err_o;

    modport master (
        output rx_valid_o, rx_data_o, rx_frame_err_o, rx_parity_err_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_valid_o, rx_data_o, rx_frame_err_o, rx_parity_err_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rcvr_os.sv
// Oversampling UART receiver with 3-sample majority vote and a show-ahead receive FIFO.
// Define UART_RCVR_PARITY_EN to build the parity state and checker; otherwise frames are parity-less.
module uart_rcvr_os #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              os_tick_i,
    input  logic                              serial_i,
    input  logic [1:0]                        parity_mode_i,
    input  logic                              stop2_i,
    input  logic                              overrun_clr_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
    output logic                              overrun_o,
    uart_rcvr_os_if.master                    rx_if
);
    localparam int M     = OVERSAMPLE / 2;
    localparam int TC_W  = $clog2(OVERSAMPLE);
    localparam int BI_W  = $clog2(DATA_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef UART_RCVR_PARITY_EN
    localparam int ENTRY_W = DATA_WIDTH + 2;
`else
    localparam int ENTRY_W = DATA_WIDTH + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RCVR_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_STOP2
    } state_t;

    state_t                r_state;
    logic                  r_sync1, r_rx_s;
    logic [TC_W-1:0]       r_tc;
    logic [BI_W-1:0]       r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_smp0, r_smp1;
    logic                  r_frame_err;
    logic                  r_stop2;
    logic                  r_par_err;
    logic                  r_par_en, r_par_odd;

    logic                  w_wrap, w_resolve, w_bit, w_push;
    logic [ENTRY_W-1:0]    w_entry;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= serial_i;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_wrap    = os_tick_i && (r_tc == TC_W'(OVERSAMPLE - 1));
    assign w_resolve = os_tick_i && (r_tc == TC_W'(M + 1));
    // Third vote is the live synchronised sample taken on the resolve tick itself.
    assign w_bit     = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
    assign w_push    = w_resolve && ((r_state == S_STOP && !r_stop2) || r_state == S_STOP2);

`ifdef UART_RCVR_PARITY_EN
    assign w_entry = {r_par_err, r_frame_err | ~w_bit, r_shift};
`else
    assign w_entry = {r_frame_err | ~w_bit, r_shift};
    logic w_unused_parity;
    assign w_unused_parity = ^{parity_mode_i, r_par_err, r_par_en, r_par_odd};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_smp0 <= 1'b1;
            r_smp1 <= 1'b1;
        end else if (os_tick_i) begin
            if (r_tc == TC_W'(M - 1)) r_smp0 <= r_rx_s;
            if (r_tc == TC_W'(M))     r_smp1 <= r_rx_s;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_tc        <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
            r_stop2     <= 1'b0;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
        end else begin
            if (r_state != S_IDLE && os_tick_i)
                r_tc <= w_wrap ? '0 : r_tc + TC_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state     <= S_START;
                        r_tc        <= '0;
                        r_frame_err <= 1'b0;
                        r_par_err   <= 1'b0;
                        r_stop2     <= stop2_i;
`ifdef UART_RCVR_PARITY_EN
                        r_par_en    <= (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
                        r_par_odd   <= (parity_mode_i == 2'b10);
`else
                        r_par_en    <= 1'b0;
                        r_par_odd   <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (w_resolve && w_bit) begin
                        r_state <= S_IDLE;
                    end else if (w_wrap) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_resolve)
                        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    if (w_wrap) begin
                        if (r_bit_idx == BI_W'(DATA_WIDTH - 1))
`ifdef UART_RCVR_PARITY_EN
                            r_state <= r_par_en ? S_PARITY : S_STOP;
`else
                            r_state <= S_STOP;
`endif
                        else
                            r_bit_idx <= r_bit_idx + BI_W'(1);
                    end
                end
`ifdef UART_RCVR_PARITY_EN
                S_PARITY: begin
                    if (w_resolve)
                        r_par_err <= ((^r_shift) ^ w_bit) != r_par_odd;
                    if (w_wrap)
                        r_state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (w_resolve) begin
                        r_frame_err <= r_frame_err | ~w_bit;
                        if (!r_stop2) r_state <= S_IDLE;
                    end else if (w_wrap) begin
                        r_state <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (w_resolve) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Receive FIFO: distributed array, head read combinationally for show-ahead.
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overrun;
    logic               w_full, w_pop, w_wr, w_nonempty;
    logic [ENTRY_W-1:0] w_head;

    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop      = w_nonempty && rx_if.rx_ready_i;
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
            else if (overrun_clr_i)         r_overrun <= 1'b0;
        end
    end

    assign fifo_count_o          = r_count;
    assign overrun_o             = r_overrun;
    assign rx_if.rx_valid_o      = w_nonempty;
    assign rx_if.rx_data_o       = w_nonempty ? w_head[DATA_WIDTH-1:0] : '0;
    assign rx_if.rx_frame_err_o  = w_nonempty & w_head[DATA_WIDTH];
`ifdef UART_RCVR_PARITY_EN
    assign rx_if.rx_parity_err_o = w_nonempty & w_head[DATA_WIDTH+1];
`else
    assign rx_if.rx_parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rcvr_os.sv
// Scoreboard bench for uart_rcvr_os: frames are built bit by bit from the character format,
// expected words are queued when sent and a monitor compares each FIFO pop.
module tb_uart_rcvr_os;
    localparam int DW    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 8;
    localparam int M     = OS / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick = 1'b0;
    logic       serial = 1'b1;
    logic [1:0] pmode = 2'b00;
    logic       stop2 = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [3:0] fifo_count;
    logic       overrun;

    uart_rcvr_os_if #(.DATA_WIDTH(DW)) rx_if ();

    uart_rcvr_os #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .os_tick_i(os_tick), .serial_i(serial),
        .parity_mode_i(pmode), .stop2_i(stop2), .overrun_clr_i(ovr_clr),
        .fifo_count_o(fifo_count), .overrun_o(overrun), .rx_if(rx_if)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; logic fe; logic pe; } exp_t;
    exp_t exp_q[$];
    logic exp_ovr = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   tick_div = 1;

    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            os_tick = (cnt == 0);
            cnt = (cnt + 1 >= tick_div) ? 0 : cnt + 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Monitor: a pop happens on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && rx_if.rx_valid_o && rx_if.rx_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: act data=%02h fe=%0b pe=%0b exp=no word",
                         rx_if.rx_data_o, rx_if.rx_frame_err_o, rx_if.rx_parity_err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rx_if.rx_data_o !== e.d || rx_if.rx_frame_err_o !== e.fe ||
                    rx_if.rx_parity_err_o !== e.pe) begin
                    errors++;
                    $display("FAIL pop_word: act data=%02h fe=%0b pe=%0b exp data=%02h fe=%0b pe=%0b",
                             rx_if.rx_data_o, rx_if.rx_frame_err_o, rx_if.rx_parity_err_o, e.d, e.fe, e.pe);
                end else begin
                    $display("pop data=%02h fe=%0b pe=%0b ok", e.d, e.fe, e.pe);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A low stop bit is released after the sampling window so the receiver's false-start logic clears.
    task automatic drive_bit(input logic v, input logic trunc, input logic spike);
        serial = v;
        if (spike) begin
            wait_clks(M * tick_div); serial = ~v;
            wait_clks(tick_div);     serial = v;
            wait_clks((OS - M - 1) * tick_div);
        end else if (!v && trunc) begin
            wait_clks((M + 3) * tick_div); serial = 1'b1;
            wait_clks((OS - M - 3) * tick_div);
        end else begin
            wait_clks(OS * tick_div);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic [1:0] pm, input logic s2,
                              input logic pflip, input logic slo1, input logic slo2, input int spike_bit);
        exp_t e;
        logic pbit;
        logic par_on;
        pmode = pm;
        stop2 = s2;
`ifdef UART_RCVR_PARITY_EN
        par_on = (pm == 2'b01) || (pm == 2'b10);
`else
        par_on = 1'b0;
`endif
        pbit = (^d) ^ (pm == 2'b10) ^ pflip;
        e.d  = d;
        e.fe = slo1 | (s2 & slo2);
        e.pe = par_on ? ((($countones(d) + int'(pbit)) % 2 == 1) != (pm == 2'b10)) : 1'b0;
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i], 1'b0, i == spike_bit);
        if (par_on) drive_bit(pbit, 1'b0, 1'b0);
        if (s2) drive_bit(~slo1, 1'b1, 1'b0);
        // Expected word is queued before the final stop bit so the monitor never sees the pop first.
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovr = 1'b1;
        $display("send data=%02h pm=%0d s2=%0b fe=%0b pe=%0b td=%0d", d, pm, s2, e.fe, e.pe, tick_div);
        drive_bit(s2 ? ~slo2 : ~slo1, 1'b1, 1'b0);
        serial = 1'b1;
        wait_clks(OS * tick_div + 4);
    endtask

    initial begin
        rx_if.rx_ready_i = 1'b0;
        wait_clks(3);
        check("rst_valid", rx_if.rx_valid_o, 0);
        check("rst_data", rx_if.rx_data_o, 0);
        check("rst_fe", rx_if.rx_frame_err_o, 0);
        check("rst_pe", rx_if.rx_parity_err_o, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        wait_clks(4);

        // 8N1 0xA5, held, then popped
        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("a5_count_held", fifo_count, 1);
        check("a5_head", rx_if.rx_data_o, 8'hA5);
        rx_if.rx_ready_i = 1'b1;
        wait_clks(3);
        check("a5_count_popped", fifo_count, 0);

`ifdef UART_RCVR_PARITY_EN
        send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h03, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, -1);
`endif
        send_frame(8'h5A, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, -1);

        // Short low glitch: must not push anything
        serial = 1'b0; wait_clks(4 * tick_div); serial = 1'b1;
        wait_clks(2 * OS * tick_div);
        check("glitch_count", fifo_count, 0);
        send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        check("after_spike_count", fifo_count, 0);

        for (int n = 0; n < 20; n++) begin
            logic [DW-1:0] d;
            logic slo;
            d = DW'($urandom);
            tick_div = $urandom_range(1, 3);
            wait_clks(4);
            slo = ($urandom_range(0, 4) == 0);
            send_frame(d, 2'($urandom), 1'($urandom), 1'($urandom), slo & 1'($urandom),
                       slo & 1'($urandom), -1);
            check("rand_count", fifo_count, exp_q.size());
            check("rand_overrun", overrun, exp_ovr);
        end

        // Overrun: nine frames into an eight-deep FIFO without popping
        tick_div = 1;
        rx_if.rx_ready_i = 1'b0;
        wait_clks(4);
        for (int n = 1; n <= 9; n++)
            send_frame(DW'(n), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("ovr_count", fifo_count, exp_q.size());
        check("ovr_flag", overrun, exp_ovr);
        check("ovr_full", fifo_count, DEPTH);
        rx_if.rx_ready_i = 1'b1;
        wait_clks(DEPTH + 4);
        check("ovr_drained", fifo_count, 0);
        check("ovr_sticky", overrun, 1);
        ovr_clr = 1'b1; wait_clks(1); ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        wait_clks(1);
        check("ovr_cleared", overrun, exp_ovr);

        // Reset in the middle of 0xFF, then a clean 0x3C
        rx_if.rx_ready_i = 1'b0;
        serial = 1'b0; wait_clks(OS * tick_div);
        serial = 1'b1; wait_clks(4 * OS * tick_div + M * tick_div);
        rst = 1'b1;
        exp_q.delete();
        wait_clks(3);
        check("midrst_valid", rx_if.rx_valid_o, 0);
        check("midrst_count", fifo_count, 0);
        wait_clks(1);
        rst = 1'b0;
        wait_clks(OS * 12);
        check("midrst_no_word", fifo_count, 0);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check("midrst_one_entry", fifo_count, 1);
        check("midrst_head", rx_if.rx_data_o, 8'h3C);
        rx_if.rx_ready_i = 1'b1;
        wait_clks(4);
        check("final_count", fifo_count, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
